// File: rtl/branch_predict_resolve_pkg.sv
// Shared CPU control encodings used by branch resolution and the branch history table.
package branch_predict_resolve_pkg;

   typedef enum logic [2:0] {
      BR_NONE = 3'b000,
      BR_JAL  = 3'b001,
      BR_JALR = 3'b010,
      BR_RSVD = 3'b011,
      BR_BEQ  = 3'b100,
      BR_BNE  = 3'b101,
      BR_BLT  = 3'b110,
      BR_BGE  = 3'b111
   } br_op_e;

   localparam int COUNT_W = 32;

   // Weakly-not-taken: one step below the taken threshold.
   function automatic int cnt_init(input int cnt_w);
      return (1 << (cnt_w - 1)) - 1;
   endfunction

endpackage

// File: rtl/branch_predict_resolve_if.sv
// EX-stage branch bundle: operands in from the pipeline, resolution results out.
interface branch_predict_resolve_if;
   logic       ex_valid;
   logic [2:0] ex_branch;
   logic       ex_zero;
   logic       ex_less;
   logic       ex_pred_taken;
   logic       redirect;
   logic       actual_taken;
   logic       pc_a_src;
   logic       pc_b_src;

   modport master (
      output ex_valid, ex_branch, ex_zero, ex_less, ex_pred_taken,
      input  redirect, actual_taken, pc_a_src, pc_b_src
   );

   modport slave (
      input  ex_valid, ex_branch, ex_zero, ex_less, ex_pred_taken,
      output redirect, actual_taken, pc_a_src, pc_b_src
   );
endinterface

// File: rtl/branch_predict_resolve_ex.sv
// Combinational branch resolution: direction, redirect and redirect-adder source selects.
module branch_predict_resolve_ex
   import branch_predict_resolve_pkg::*;
(
   branch_predict_resolve_if.slave ex_if,
   output logic                    o_is_cond,
   output logic                    o_mispredict
);
   br_op_e w_op;
   logic   w_actual;
   logic   w_redirect;
   logic   w_is_cond;
   logic   w_is_jalr;

   assign w_op = br_op_e'(ex_if.ex_branch);

   always_comb begin
      w_actual   = 1'b0;
      w_redirect = 1'b0;
      w_is_cond  = 1'b0;
      w_is_jalr  = 1'b0;
      if (ex_if.ex_valid) begin
         case (w_op)
            BR_JAL: begin
               w_actual   = 1'b1;
               w_redirect = !ex_if.ex_pred_taken;
            end
            BR_JALR: begin
               w_actual   = 1'b1;
               w_redirect = 1'b1;
               w_is_jalr  = 1'b1;
            end
            BR_BEQ: begin
               w_is_cond = 1'b1;
               w_actual  = ex_if.ex_zero;
            end
            BR_BNE: begin
               w_is_cond = 1'b1;
               w_actual  = !ex_if.ex_zero;
            end
            BR_BLT: begin
               w_is_cond = 1'b1;
               w_actual  = ex_if.ex_less;
            end
            BR_BGE: begin
               w_is_cond = 1'b1;
               w_actual  = !ex_if.ex_less;
            end
            default: begin
               w_actual = 1'b0;
            end
         endcase
         if (w_is_cond) begin
            w_redirect = (w_actual != ex_if.ex_pred_taken);
         end
      end
   end

   // A not-taken redirect falls back to pc+4, so both selects stay low.
   assign ex_if.redirect     = w_redirect;
   assign ex_if.actual_taken = w_actual;
   assign ex_if.pc_a_src     = w_redirect & w_actual;
   assign ex_if.pc_b_src     = w_redirect & w_actual & w_is_jalr;
   assign o_is_cond          = w_is_cond;
   assign o_mispredict       = w_is_cond & w_redirect;
endmodule

// File: rtl/branch_predict_resolve_sat_counter.sv
// One BHT entry: saturating up/down counter, reset to weakly-not-taken.
module sat_counter
   import branch_predict_resolve_pkg::*;
#(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             en,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);
   localparam logic [CNT_W-1:0] INIT = CNT_W'(cnt_init(CNT_W));
   localparam logic [CNT_W-1:0] MAX  = '1;

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_cnt <= INIT;
      end else if (en) begin
         if (inc && r_cnt != MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end else if (!inc && r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
      end
   end

   assign cnt = r_cnt;
endmodule

// File: rtl/branch_predict_resolve.sv
// Bimodal branch predictor with EX-stage resolution and resolved/mispredict counters.
module branch_predict_resolve
   import branch_predict_resolve_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int ENTRIES = 64,
   parameter int CNT_W   = 2
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic [XLEN-1:0]    if_pc,
   output logic               if_pred_taken,
   input  logic               ex_valid,
   input  logic               ex_stall,
   input  logic [XLEN-1:0]    ex_pc,
   input  logic [2:0]         ex_branch,
   input  logic               ex_zero,
   input  logic               ex_less,
   input  logic               ex_pred_taken,
   output logic               pc_a_src,
   output logic               pc_b_src,
   output logic               redirect,
   output logic               actual_taken,
   output logic [COUNT_W-1:0] br_count,
   output logic [COUNT_W-1:0] miss_count
);
   localparam int IDX_W = $clog2(ENTRIES);

   logic [IDX_W-1:0]   w_if_idx;
   logic [IDX_W-1:0]   w_ex_idx;
   logic [CNT_W-1:0]   w_cnt [ENTRIES];
   logic               w_is_cond;
   logic               w_mispredict;
   logic               w_update;
   logic [COUNT_W-1:0] r_br_count;
   logic [COUNT_W-1:0] r_miss_count;
   logic               w_unused;

   assign w_if_idx = if_pc[IDX_W+1:2];
   assign w_ex_idx = ex_pc[IDX_W+1:2];
   assign w_unused = &{1'b0, if_pc[XLEN-1:IDX_W+2], if_pc[1:0],
                       ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0]};

   branch_predict_resolve_if u_ex_if ();

   assign u_ex_if.ex_valid      = ex_valid;
   assign u_ex_if.ex_branch     = ex_branch;
   assign u_ex_if.ex_zero       = ex_zero;
   assign u_ex_if.ex_less       = ex_less;
   assign u_ex_if.ex_pred_taken = ex_pred_taken;

   branch_predict_resolve_ex u_ex (
      .ex_if        (u_ex_if),
      .o_is_cond    (w_is_cond),
      .o_mispredict (w_mispredict)
   );

   assign redirect     = u_ex_if.redirect;
   assign actual_taken = u_ex_if.actual_taken;
   assign pc_a_src     = u_ex_if.pc_a_src;
   assign pc_b_src     = u_ex_if.pc_b_src;

   // Only conditional branches train the table; jumps are always taken.
   assign w_update = w_is_cond & ~ex_stall;

   generate
      for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_bht
         sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk  (clk),
            .rstn (rstn),
            .en   (w_update && (w_ex_idx == IDX_W'(gi))),
            .inc  (actual_taken),
            .cnt  (w_cnt[gi])
         );
      end
   endgenerate

   assign if_pred_taken = rstn & w_cnt[w_if_idx][CNT_W-1];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_br_count   <= '0;
         r_miss_count <= '0;
      end else if (w_update) begin
         if (r_br_count != '1) begin
            r_br_count <= r_br_count + COUNT_W'(1);
         end
         if (w_mispredict && r_miss_count != '1) begin
            r_miss_count <= r_miss_count + COUNT_W'(1);
         end
      end
   end

   assign br_count   = r_br_count;
   assign miss_count = r_miss_count;
endmodule
